// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic RAM_RD = 1'b1;
    localparam logic RAM_WR = 1'b0;

    localparam int REQ_EXEC  = 0;
    localparam int REQ_STACK = 1;
    localparam int REQ_DEBUG = 2;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake plus RAM-side port of the arbiter, bundled as one interface.
interface ram_arb_if #(
    parameter int NREQ = 3,
    parameter int AW   = 8,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ-1:0]    lock;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic               busy;
    logic               E_RAM;
    logic               rw_ram;
    logic [AW-1:0]      RAM_ADDRESS;
    logic [DW-1:0]      RAM_WDATA;
    logic [DW-1:0]      RAM_DATABUS;

    // master: requesters and the RAM macro; slave: the arbiter
    modport master (
        output req, we, lock, addr, wdata, RAM_DATABUS,
        input  gnt, ack, rdata, busy, E_RAM, rw_ram, RAM_ADDRESS, RAM_WDATA
    );

    modport slave (
        input  req, we, lock, addr, wdata, RAM_DATABUS,
        output gnt, ack, rdata, busy, E_RAM, rw_ram, RAM_ADDRESS, RAM_WDATA
    );
endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational winner select: round-robin from rr_ptr, or fixed priority with index 0 highest.
module rr_pick #(
    parameter int NREQ      = 3,
    parameter int PRIO_MODE = 0,
    localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IW-1:0]   win_idx,
    output logic            win_vld
);

    always_comb begin
        int c;
        c       = 0;
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            c = (PRIO_MODE != 0) ? i : (int'(rr_ptr) + i) % NREQ;
            if (!win_vld && req[IW'(c)]) begin
                win_vld = 1'b1;
                win_idx = IW'(c);
            end
        end
        if (win_vld) begin
            win_oh[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises the execute, stack and debug paths onto the single data-RAM port.
//
//   state | meaning
//   IDLE  | no access in flight; arbitrate among pending requests
//   ISSUE | E_RAM pulsed for one cycle with the latched address/direction/data
//   WAIT  | counting down RAM latency; read data captured on the last count
//   DONE  | ack pulse for the owner; relock or release the port
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int RAM_LAT   = 1,
    parameter int PRIO_MODE = 0,
    parameter int LOCK_MAX  = 2
) (
    input  logic      clock,
    input  logic      reset,
    ram_arb_if.slave  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LW = $clog2(LOCK_MAX + 1);

    arb_state_t      state;
    logic [IW-1:0]   cur;
    logic [IW-1:0]   rr_ptr;
    logic [LW-1:0]   lock_cnt;
    logic [2:0]      wait_cnt;

    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic            win_vld;
    logic [IW-1:0]   sel;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            relock;

    logic [NREQ-1:0] gnt_r;
    logic [NREQ-1:0] ack_r;
    logic [DW-1:0]   rdata_r;
    logic            busy_r;
    logic            e_ram_r;
    logic            rw_r;
    logic [AW-1:0]   addr_r;
    logic [DW-1:0]   wdata_r;

    rr_pick #(
        .NREQ      (NREQ),
        .PRIO_MODE (PRIO_MODE)
    ) u_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // Fields come from the new winner in IDLE, or from the current owner when relocking in DONE.
    assign sel       = (state == DONE) ? cur : win_idx;
    assign sel_we    = bus.we[sel];
    assign sel_addr  = bus.addr[int'(sel)*AW +: AW];
    assign sel_wdata = bus.wdata[int'(sel)*DW +: DW];
    assign relock    = bus.lock[cur] && bus.req[cur] && (int'(lock_cnt) < LOCK_MAX - 1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            cur      <= '0;
            rr_ptr   <= '0;
            lock_cnt <= '0;
            wait_cnt <= '0;
            gnt_r    <= '0;
            ack_r    <= '0;
            rdata_r  <= '0;
            busy_r   <= 1'b0;
            e_ram_r  <= 1'b0;
            rw_r     <= RAM_RD;
            addr_r   <= '0;
            wdata_r  <= '0;
        end else begin
            ack_r <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        cur     <= win_idx;
                        gnt_r   <= win_oh;
                        busy_r  <= 1'b1;
                        e_ram_r <= 1'b1;
                        rw_r    <= sel_we ? RAM_WR : RAM_RD;
                        addr_r  <= sel_addr;
                        wdata_r <= sel_wdata;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    e_ram_r  <= 1'b0;
                    wait_cnt <= 3'(RAM_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        ack_r[cur] <= 1'b1;
                        if (rw_r == RAM_RD) begin
                            rdata_r <= bus.RAM_DATABUS;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                DONE: begin
                    rr_ptr <= (cur == IW'(NREQ - 1)) ? '0 : cur + IW'(1);
                    if (relock) begin
                        lock_cnt <= lock_cnt + LW'(1);
                        e_ram_r  <= 1'b1;
                        rw_r     <= sel_we ? RAM_WR : RAM_RD;
                        addr_r   <= sel_addr;
                        wdata_r  <= sel_wdata;
                        state    <= ISSUE;
                    end else begin
                        lock_cnt <= '0;
                        gnt_r    <= '0;
                        busy_r   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt         = gnt_r;
    assign bus.ack         = ack_r;
    assign bus.rdata       = rdata_r;
    assign bus.busy        = busy_r;
    assign bus.E_RAM       = e_ram_r;
    assign bus.rw_ram      = rw_r;
    assign bus.RAM_ADDRESS = addr_r;
    assign bus.RAM_WDATA   = wdata_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a round-robin/1-cycle-RAM instance and a fixed-priority/4-cycle-RAM instance.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int LOCK_MAX = 2;

    typedef struct {
        bit       we;
        bit [7:0] addr;
        bit [7:0] wdata;
    } op_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ram_arb_if #(.NREQ(3), .AW(8), .DW(8)) bus_a ();
    ram_arb_if #(.NREQ(3), .AW(8), .DW(8)) bus_b ();

    ram_port_arbiter #(.NREQ(3), .AW(8), .DW(8), .RAM_LAT(1), .PRIO_MODE(0), .LOCK_MAX(LOCK_MAX))
        dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    ram_port_arbiter #(.NREQ(3), .AW(8), .DW(8), .RAM_LAT(4), .PRIO_MODE(1), .LOCK_MAX(LOCK_MAX))
        dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    logic [2:0]  req_d [2];
    logic [2:0]  we_d  [2];
    logic [2:0]  lock_d[2];
    logic [23:0] addr_d[2];
    logic [23:0] wdata_d[2];
    logic [7:0]  dbus  [2];

    assign bus_a.req = req_d[0];   assign bus_b.req = req_d[1];
    assign bus_a.we = we_d[0];     assign bus_b.we = we_d[1];
    assign bus_a.lock = lock_d[0]; assign bus_b.lock = lock_d[1];
    assign bus_a.addr = addr_d[0]; assign bus_b.addr = addr_d[1];
    assign bus_a.wdata = wdata_d[0]; assign bus_b.wdata = wdata_d[1];
    assign bus_a.RAM_DATABUS = dbus[0]; assign bus_b.RAM_DATABUS = dbus[1];

    logic [2:0] gnt_s[2], ack_s[2];
    logic [7:0] rdata_s[2], ra_s[2], rwd_s[2];
    logic       busy_s[2], e_s[2], rw_s[2];

    assign gnt_s[0] = bus_a.gnt;           assign gnt_s[1] = bus_b.gnt;
    assign ack_s[0] = bus_a.ack;           assign ack_s[1] = bus_b.ack;
    assign rdata_s[0] = bus_a.rdata;       assign rdata_s[1] = bus_b.rdata;
    assign ra_s[0] = bus_a.RAM_ADDRESS;    assign ra_s[1] = bus_b.RAM_ADDRESS;
    assign rwd_s[0] = bus_a.RAM_WDATA;     assign rwd_s[1] = bus_b.RAM_WDATA;
    assign busy_s[0] = bus_a.busy;         assign busy_s[1] = bus_b.busy;
    assign e_s[0] = bus_a.E_RAM;           assign e_s[1] = bus_b.E_RAM;
    assign rw_s[0] = bus_a.rw_ram;         assign rw_s[1] = bus_b.rw_ram;

    // RAM macro model: read data valid only in the cycle exactly RAM_LAT after the issue cycle
    logic [7:0] mem    [2][256];
    logic [7:0] mem_ref[2][256];
    int         iss_cyc [2];
    logic [7:0] iss_addr[2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (e_s[d]) begin
                if (rw_s[d] == RAM_WR) mem[d][ra_s[d]] = rwd_s[d];
                else begin
                    iss_cyc[d]  = cyc;
                    iss_addr[d] = ra_s[d];
                end
            end
            dbus[d] = (cyc == iss_cyc[d] + lat_of(d)) ? mem[d][iss_addr[d]] : ~mem[d][iss_addr[d]];
        end
    end

    // Reference model state
    op_t        q[3][$];
    bit         lk[3];
    int         ptr_m[2];
    logic [7:0] rdata_m[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int pick(input logic [2:0] pend, input int ptr, input int fixed);
        int c;
        for (int k = 0; k < 3; k++) begin
            c = (fixed != 0) ? k : (ptr + k) % 3;
            if (pend[c]) return c;
        end
        return 0;
    endfunction

    task automatic add_op(input int i, input bit we, input bit [7:0] a, input bit [7:0] wd);
        op_t o;
        o.we = we; o.addr = a; o.wdata = wd;
        q[i].push_back(o);
    endtask

    task automatic set_fields(input int d, input int i);
        if (q[i].size() > 0) begin
            req_d[d][i]          = 1'b1;
            we_d[d][i]           = q[i][0].we;
            addr_d[d][i*8 +: 8]  = q[i][0].addr;
            wdata_d[d][i*8 +: 8] = q[i][0].wdata;
            lock_d[d][i]         = lk[i];
        end else begin
            req_d[d][i]  = 1'b0;
            lock_d[d][i] = 1'b0;
        end
    endtask

    task automatic check_reset(input int d);
        check_val($sformatf("d%0d.rst_ctl", d), {23'd0, gnt_s[d], ack_s[d], busy_s[d], e_s[d], rw_s[d]}, 32'h1);
        check_val($sformatf("d%0d.rst_rdata", d), {24'd0, rdata_s[d]}, 32'h0);
        check_val($sformatf("d%0d.rst_addr", d), {24'd0, ra_s[d]}, 32'h0);
        check_val($sformatf("d%0d.rst_wdata", d), {24'd0, rwd_s[d]}, 32'h0);
    endtask

    // Drives all queued operations, predicts order/timing/data access by access.
    task automatic run_batch(input int d);
        int  lat, w, run, t_last, t, e_cnt, wait_n, exp_gap;
        bit  cont, got, first;
        op_t op;
        lat = lat_of(d); run = 0; cont = 0; first = 1; w = 0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) set_fields(d, i);
        t_last = cyc;
        while (q[0].size() + q[1].size() + q[2].size() > 0) begin
            if (!cont) w = pick({q[2].size() > 0, q[1].size() > 0, q[0].size() > 0}, ptr_m[d], d);
            op = q[w][0];
            e_cnt = 0; got = 0; wait_n = 0;
            while (!got && wait_n < 40) begin
                @(negedge clock);
                wait_n++;
                if (e_s[d]) begin
                    e_cnt++;
                    check_val($sformatf("d%0d.iss_addr", d), {24'd0, ra_s[d]}, {24'd0, op.addr});
                    check_val($sformatf("d%0d.iss_rw", d), {31'd0, rw_s[d]}, {31'd0, ~op.we});
                    if (op.we) check_val($sformatf("d%0d.iss_wdata", d), {24'd0, rwd_s[d]}, {24'd0, op.wdata});
                end
                got = (ack_s[d] != 3'b000);
            end
            if (!got) begin
                check_val($sformatf("d%0d.ack_timeout", d), 32'd0, 32'd1);
                for (int i = 0; i < 3; i++) q[i].delete();
                req_d[d] = 3'b000; lock_d[d] = 3'b000;
                return;
            end
            t = cyc;
            exp_gap = (first || cont) ? 2 + lat : 3 + lat;
            check_val($sformatf("d%0d.ack_who", d), {29'd0, ack_s[d]}, 32'(1 << w));
            check_val($sformatf("d%0d.gnt_at_ack", d), {29'd0, gnt_s[d]}, 32'(1 << w));
            check_val($sformatf("d%0d.e_ram_pulses", d), 32'(e_cnt), 32'd1);
            check_val($sformatf("d%0d.ack_gap", d), 32'(t - t_last), 32'(exp_gap));
            if (op.we) begin
                check_val($sformatf("d%0d.rdata_hold", d), {24'd0, rdata_s[d]}, {24'd0, rdata_m[d]});
                mem_ref[d][op.addr] = op.wdata;
            end else begin
                check_val($sformatf("d%0d.rdata", d), {24'd0, rdata_s[d]}, {24'd0, mem_ref[d][op.addr]});
                rdata_m[d] = mem_ref[d][op.addr];
            end
            void'(q[w].pop_front());
            ptr_m[d] = (w + 1) % 3;
            cont = lk[w] && (q[w].size() > 0) && (run < LOCK_MAX - 1);
            run  = cont ? run + 1 : 0;
            set_fields(d, w);
            t_last = t;
            first  = 0;
        end
        @(negedge clock);
        check_val($sformatf("d%0d.idle_after", d), {25'd0, busy_s[d], gnt_s[d], ack_s[d]}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        int nops;
        for (int d = 0; d < 2; d++) begin
            req_d[d] = '0; we_d[d] = '0; lock_d[d] = '0; addr_d[d] = '0; wdata_d[d] = '0;
            iss_cyc[d] = -100; iss_addr[d] = '0; ptr_m[d] = 0; rdata_m[d] = '0;
            for (int a = 0; a < 256; a++) begin
                v = 8'($urandom);
                mem[d][a] = v; mem_ref[d][a] = v;
            end
            mem[d][8'h30] = 8'h5A; mem_ref[d][8'h30] = 8'h5A;
        end
        for (int i = 0; i < 3; i++) lk[i] = 1'b0;

        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset(0);
        check_reset(1);
        reset = 1'b1;

        // single read 0x30, then locked stack pushes against a pending execute read
        add_op(REQ_EXEC, 1'b0, 8'h30, 8'h00);
        run_batch(0);
        lk[REQ_STACK] = 1'b1;
        add_op(REQ_STACK, 1'b1, 8'h07, 8'hAA);
        add_op(REQ_STACK, 1'b1, 8'h08, 8'hBB);
        add_op(REQ_STACK, 1'b1, 8'h09, 8'hCC);
        add_op(REQ_EXEC, 1'b0, 8'h07, 8'h00);
        run_batch(0);
        lk[REQ_STACK] = 1'b0;
        add_op(REQ_DEBUG, 1'b1, 8'h7F, 8'hC3);
        run_batch(0);
        add_op(REQ_EXEC, 1'b0, 8'h08, 8'h00);
        add_op(REQ_EXEC, 1'b0, 8'h7F, 8'h00);
        add_op(REQ_STACK, 1'b0, 8'h09, 8'h00);
        add_op(REQ_DEBUG, 1'b0, 8'h30, 8'h00);
        run_batch(0);

        // fixed priority, 4-cycle RAM
        add_op(REQ_EXEC, 1'b0, 8'h30, 8'h00);
        run_batch(1);
        add_op(REQ_EXEC, 1'b0, 8'h01, 8'h00);
        add_op(REQ_EXEC, 1'b1, 8'h02, 8'h66);
        add_op(REQ_STACK, 1'b0, 8'h02, 8'h00);
        add_op(REQ_DEBUG, 1'b0, 8'h03, 8'h00);
        run_batch(1);

        // leave dut_a's pointer at 2, then reset dut_b mid-access
        add_op(REQ_STACK, 1'b0, 8'h04, 8'h00);
        run_batch(0);
        @(negedge clock);
        req_d[1] = 3'b001; we_d[1] = 3'b000; addr_d[1] = 24'h000010;
        repeat (3) @(negedge clock);
        check_val("d1.busy_mid", {31'd0, busy_s[1]}, 32'd1);
        reset = 1'b0;
        req_d[1] = 3'b000;
        @(negedge clock);
        check_reset(1);
        check_reset(0);
        @(negedge clock);
        check_val("d1.no_ack_abort", {29'd0, ack_s[1]}, 32'd0);
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin ptr_m[d] = 0; rdata_m[d] = '0; end
        add_op(REQ_STACK, 1'b0, 8'h05, 8'h00);
        add_op(REQ_DEBUG, 1'b0, 8'h06, 8'h00);
        run_batch(0);

        // randomized batches on both instances
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 12; b++) begin
                for (int i = 0; i < 3; i++) begin
                    lk[i] = ($urandom_range(0, 2) == 0);
                    nops = $urandom_range(0, 3);
                    for (int k = 0; k < nops; k++)
                        add_op(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
                end
                if (q[0].size() + q[1].size() + q[2].size() == 0)
                    add_op($urandom_range(0, 2), 1'b0, 8'($urandom_range(0, 15)), 8'h00);
                run_batch(d);
                for (int i = 0; i < 3; i++) lk[i] = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the single internal data-RAM port (8-bit address, 8-bit data) between three requesters: the execute path (operand/DIR access), the stack path (SP_PUSH/SP_POP), and the debug/SFR-shadow path. It owns E_RAM, rw_ram and RAM_ADDRESS, and sequences one access at a time: arbitrate, issue, wait for RAM latency, then acknowledge. A lock option keeps back-to-back read-modify-write pairs atomic. Starvation is bounded.

Parameters:
NREQ, 3, number of requesters; index 0 = execute, 1 = stack, 2 = debug.
AW, 8, RAM address width.
DW, 8, RAM data width.
RAM_LAT, 1, cycles from the issue cycle until RAM_DATABUS is valid; legal range 1..7.
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority with index 0 highest.
LOCK_MAX, 2, maximum consecutive locked accesses by one requester before the lock is ignored.

Ports:
clock  in  1  system clock; all state updates on its rising edge.
reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
req  in  NREQ  per-requester access request, level.
we  in  NREQ  per-requester access type: 1 = write, 0 = read.
lock  in  NREQ  per-requester request to keep the grant for the next access.
addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
wdata  in  NREQ*DW  packed write data, same packing as addr.
gnt  out  NREQ  one-hot grant, level.
ack  out  NREQ  one-hot completion pulse, one cycle wide.
rdata  out  DW  read data, shared by all requesters.
busy  out  1  arbiter is not in IDLE.
E_RAM  out  1  RAM enable.
rw_ram  out  1  RAM direction: 1 = read, 0 = write.
RAM_ADDRESS  out  AW  RAM address.
RAM_WDATA  out  DW  RAM write data.
RAM_DATABUS  in  DW  RAM read data.

Behaviour:
- Reset values (reset low at a rising edge): gnt = 0, ack = 0, rdata = 0, busy = 0, E_RAM = 0, rw_ram = 1, RAM_ADDRESS = 0, RAM_WDATA = 0. Internal: state = IDLE, rr_ptr = 0, lock_cnt = 0, wait_cnt = 0.
- Reset mid-access aborts the access in the same edge. No ack is produced for the aborted access.
- All outputs are registered.
- IDLE:
  - If req != 0, pick winner w.
    - Round-robin: first set req bit at or after rr_ptr, wrapping modulo NREQ.
    - Fixed priority: lowest set index.
  - Latch cur = w, plus we[w], addr[w] and wdata[w]. Set gnt[w] = 1 and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (one cycle):
  - E_RAM = 1, rw_ram = ~we_l, RAM_ADDRESS = addr_l, RAM_WDATA = wdata_l.
  - Load wait_cnt = RAM_LAT - 1 and go to WAIT.
- WAIT:
  - E_RAM = 0, RAM_ADDRESS is held.
  - Decrement wait_cnt. When it is 0, go to DONE; if the access is a read, capture rdata = RAM_DATABUS.
- DONE (one cycle):
  - ack[cur] = 1 and gnt[cur] stays 1.
  - rdata is unchanged on writes.
  - rr_ptr = (cur + 1) mod NREQ.
- Next-state rule from DONE:
  - If lock[cur] and req[cur] and lock_cnt < LOCK_MAX - 1: increment lock_cnt, re-latch from requester cur, go to ISSUE; gnt is held.
  - Otherwise: lock_cnt = 0, gnt = 0, go to IDLE.
- Latency: req first seen high at edge T gives ISSUE at T+1, ack at T+2+RAM_LAT. For RAM_LAT = 1, ack is at T+3.
- Locked back-to-back accesses: one access every 2 + RAM_LAT cycles.
- Request lines: req only needs to stay high until gnt. Access fields are latched at grant, so dropping req afterwards does not cancel the access; ack still pulses. To avoid a duplicate access, a requester drops req no later than its ack cycle.
- A request arriving while busy waits for IDLE. No lookahead: there is at least one IDLE cycle between accesses from different requesters.
- rr_ptr wraps from NREQ-1 to 0.

Decomposition:
- Package ram_arb_pkg holds:
  - the state encoding IDLE / ISSUE / WAIT / DONE;
  - constants RAM_RD = 1'b1 and RAM_WR = 1'b0;
  - the requester index constants REQ_EXEC = 0, REQ_STACK = 1, REQ_DEBUG = 2.
- One sub-module, rr_pick: combinational winner select from (req, rr_ptr, PRIO_MODE), producing a one-hot output and an index.

Test Plan:
- Single read, RAM_LAT = 1: memory at 0x30 holds 0x5A; req[0] = 1, we = 0, addr = 0x30 at edge T.
  -> gnt[0] at T+1; E_RAM = 1, rw_ram = 1, RAM_ADDRESS = 0x30 at T+1; ack[0] and rdata = 0x5A at T+3.
- Simultaneous requests, PRIO_MODE = 0: req = 3'b111 held continuously, all reads.
  -> grants in the order 0, 1, 2, 0; each ack is 4 cycles after the previous one.
  - Same stimulus with PRIO_MODE = 1 -> requester 0 wins every arbitration.
- Locked push, LOCK_MAX = 2: req[1] with lock[1] = 1; write 0x07 -> 0xAA, then write 0x08 -> 0xBB. req[0] is also pending throughout.
  -> both stack writes complete before gnt[0]; gnt[1] never drops between the two accesses.
  - Then a third locked req[1] -> lock ignored; gnt[0] is granted next.
- Write: req[2], we = 1, addr = 0x7F, wdata = 0xC3.
  -> rw_ram = 0, RAM_WDATA = 0xC3 in ISSUE; rdata is unchanged; ack[2] is pulsed.
- RAM_LAT = 4: single read.
  -> ack at T+6; E_RAM is high for exactly one cycle.
- Reset mid-access: reset driven low during WAIT.
  -> next edge: all outputs at reset values, no ack. After reset is released, req = 3'b110 -> requester 1 is granted first (rr_ptr = 0, so the scan from 0 finds index 1).
